controller: RTL and testbench



---
 rtl/mips_pkg.sv | 47 ++++
 rtl/alu_decoder.sv | 32 +++
 rtl/controller.sv | 88 ++++++++
 tb/tb_controller.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU operation encodings and the decode-stage
// control bundle for the MIPS-subset core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    branch;
        logic    jump;
        logic    regdst;
        logic    alusrc;
        logic    memwrite;
        logic    memread;
        logic    memtoreg;
        logic    regwrite;
        logic    flush;
        alu_op_e alucont;
    } ctrl_t;

    // The nop bundle doubles as the reset value of the control register.
    function automatic ctrl_t nop_ctrl();
        ctrl_t c;
        c         = '0;
        c.alucont = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to an ALU operation; anything unrecognised
// falls back to add and is flagged so the main decoder can treat it as a nop.
module alu_decoder
    import mips_pkg::*;
(
    input  logic       rtype,
    input  logic [5:0] funct,
    output logic [2:0] alucont,
    output logic       funct_valid
);

    alu_op_e op_sel;

    always_comb begin
        op_sel      = ALU_ADD;
        funct_valid = 1'b0;
        if (rtype) begin
            funct_valid = 1'b1;
            case (funct)
                F_ADD:   op_sel = ALU_ADD;
                F_SUB:   op_sel = ALU_SUB;
                F_AND:   op_sel = ALU_AND;
                F_OR:    op_sel = ALU_OR;
                F_SLT:   op_sel = ALU_SLT;
                default: funct_valid = 1'b0;
            endcase
        end
    end

    assign alucont = op_sel;

endmodule

// File: rtl/controller.sv
// Decode-stage main controller: decodes op/funct into the datapath control
// bundle and registers it so downstream sees one stable set per cycle.
module controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       branch,
    output logic       jump,
    output logic       regdst,
    output logic       alusrc,
    output logic       memwrite,
    output logic       memread,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       flush,
    output logic [2:0] alucont
);

    logic [2:0] r_alucont;
    logic       r_valid;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;

    alu_decoder u_alu_decoder (
        .rtype       (op == OP_RTYPE),
        .funct       (funct),
        .alucont     (r_alucont),
        .funct_valid (r_valid)
    );

    always_comb begin
        ctrl_d = nop_ctrl();
        case (op)
            OP_RTYPE: begin
                if (r_valid) begin
                    ctrl_d.regdst   = 1'b1;
                    ctrl_d.regwrite = 1'b1;
                    ctrl_d.alucont  = alu_op_e'(r_alucont);
                end
            end
            OP_ADDI: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
            end
            OP_J: begin
                ctrl_d.jump  = 1'b1;
                ctrl_d.flush = 1'b1;
            end
            OP_LB: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memread  = 1'b1;
                ctrl_d.memtoreg = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            OP_SB: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            default: ctrl_d = nop_ctrl();
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= nop_ctrl();
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign branch   = ctrl_q.branch;
    assign jump     = ctrl_q.jump;
    assign regdst   = ctrl_q.regdst;
    assign alusrc   = ctrl_q.alusrc;
    assign memwrite = ctrl_q.memwrite;
    assign memread  = ctrl_q.memread;
    assign memtoreg = ctrl_q.memtoreg;
    assign regwrite = ctrl_q.regwrite;
    assign flush    = ctrl_q.flush;
    assign alucont  = ctrl_q.alucont;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: literal expectations per instruction plus a
// per-cycle comparison against an instruction-class model.
module tb_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       branch, jump, regdst, alusrc, memwrite, memread, memtoreg, regwrite, flush;
    logic [2:0] alucont;

    int unsigned errors = 0;
    int unsigned checks = 0;

    controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .branch   (branch),
        .jump     (jump),
        .regdst   (regdst),
        .alusrc   (alusrc),
        .memwrite (memwrite),
        .memread  (memread),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .flush    (flush),
        .alucont  (alucont)
    );

    always #5 clk = ~clk;

    // Bundle order: branch jump regdst alusrc memwrite memread memtoreg regwrite flush alucont[2:0]
    function automatic logic [11:0] dut_bundle();
        return {branch, jump, regdst, alusrc, memwrite, memread, memtoreg,
                regwrite, flush, alucont};
    endfunction

    // Model: classify the instruction, then apply the per-class control rules.
    function automatic logic [11:0] model(input logic rst, input logic [5:0] o, input logic [5:0] f);
        bit is_r, is_addi, is_beq, is_j, is_lb, is_sb;
        logic [2:0] alu;
        is_r    = 0; is_addi = 0; is_beq = 0; is_j = 0; is_lb = 0; is_sb = 0;
        alu     = 3'd2;
        if (!rst) begin
            if (o == 6'd0) begin
                is_r = 1;
                if      (f == 6'd32) alu = 3'd2;
                else if (f == 6'd34) alu = 3'd6;
                else if (f == 6'd36) alu = 3'd0;
                else if (f == 6'd37) alu = 3'd1;
                else if (f == 6'd42) alu = 3'd7;
                else is_r = 0;
            end
            is_addi = (o == 6'd8);
            is_beq  = (o == 6'd4);
            is_j    = (o == 6'd2);
            is_lb   = (o == 6'd32);
            is_sb   = (o == 6'd40);
        end
        return {is_beq, is_j, is_r, (is_addi | is_lb | is_sb), is_sb, is_lb, is_lb,
                (is_r | is_addi | is_lb), is_j, alu};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    logic [11:0] exp_q;
    bit          exp_valid = 0;

    always @(posedge clk) begin
        exp_q     <= model(reset, op, funct);
        exp_valid <= 1;
    end

    always @(negedge clk) begin
        if (exp_valid) check("model", dut_bundle(), exp_q);
    end

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] instr;
        logic [11:0] exp;
    } vec_t;

    localparam logic [11:0] NOP = 12'b0_0_0_0_0_0_0_0_0_010;

    vec_t vecs[$] = '{
        '{"reset0",    1'b1, 32'h00000020, NOP},
        '{"reset1",    1'b1, 32'h00000020, NOP},
        '{"add",       1'b0, 32'h00221820, 12'b0_0_1_0_0_0_0_1_0_010},
        '{"sub",       1'b0, 32'h00221822, 12'b0_0_1_0_0_0_0_1_0_110},
        '{"and",       1'b0, 32'h00221824, 12'b0_0_1_0_0_0_0_1_0_000},
        '{"or",        1'b0, 32'h00221825, 12'b0_0_1_0_0_0_0_1_0_001},
        '{"slt",       1'b0, 32'h0022182a, 12'b0_0_1_0_0_0_0_1_0_111},
        '{"addi",      1'b0, 32'h20220014, 12'b0_0_0_1_0_0_0_1_0_010},
        '{"beq",       1'b0, 32'h10220005, 12'b1_0_0_0_0_0_0_0_0_010},
        '{"j",         1'b0, 32'h0800000a, 12'b0_1_0_0_0_0_0_0_1_010},
        '{"add_after_j", 1'b0, 32'h00221820, 12'b0_0_1_0_0_0_0_1_0_010},
        '{"lb",        1'b0, 32'h80220005, 12'b0_0_0_1_0_1_1_1_0_010},
        '{"sb",        1'b0, 32'ha0220005, 12'b0_0_0_1_1_0_0_0_0_010},
        '{"bad_op",    1'b0, 32'hfc000000, NOP},
        '{"bad_funct", 1'b0, 32'h00000003, NOP},
        '{"nop_sll",   1'b0, 32'h00000000, NOP},
        '{"slt2",      1'b0, 32'h0022182a, 12'b0_0_1_0_0_0_0_1_0_111},
        '{"reset_j",   1'b1, 32'h0800000a, NOP},
        '{"j_after_rst", 1'b0, 32'h0800000a, 12'b0_1_0_0_0_0_0_0_1_010},
        '{"lb2",       1'b0, 32'h80220005, 12'b0_0_0_1_0_1_1_1_0_010}
    };

    initial begin
        reset = 1'b1;
        op    = '0;
        funct = 6'b100000;
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            op    = vecs[i].instr[31:26];
            funct = vecs[i].instr[5:0];
            @(posedge clk);
            #1;
            check(vecs[i].name, dut_bundle(), vecs[i].exp);
            // Input changes between edges must not disturb the registered bundle.
            op    = 6'b000010;
            funct = 6'b101010;
            #2;
            check({vecs[i].name, "_hold"}, dut_bundle(), vecs[i].exp);
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
